// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop phase.
// Bit timing is counted in s_tick pulses; the baud counter runs only while a frame is active.
module uart_tx_ctrl #(
  parameter int DBIT       = 8,
  parameter int OS_TICK    = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_data,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            baud_en
);

  localparam int TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);

  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shift;
  logic            parity_bit;

  // tx is assigned from the current state, so the line follows each state/bit change one clk later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shift      <= tx_data;
            parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
            tick_cnt   <= '0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          tx <= shift[0];
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shift    <= shift >> 1;
              // The bit counter holds at its terminal value rather than wrapping.
              if (bit_cnt == BIT_LAST) begin
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          tx <= parity_bit;
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              tx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // The done pulse marks the final stop tick itself, while the state is still STOP.
  assign tx_done_tick = (state == STOP) && s_tick && (tick_cnt == SB_LAST);
  assign baud_en      = tx_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances (plain, even parity, odd parity, two stop bits)
// share one stimulus stream and their serial frames are sampled at mid-bit.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] tx_data;

  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [3:0] baud_w;

  int compared;
  int mismatched;

  logic [10:0] cap [4];
  int          done_idx [4];
  int          done_cnt [4];
  logic        busy_ok [4];

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    int         inject_at;
  } vec_t;

  vec_t vecs [6];

  uart_tx_ctrl #(.DBIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_plain (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .baud_en(baud_w[0]));

  uart_tx_ctrl #(.DBIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .baud_en(baud_w[1]));

  uart_tx_ctrl #(.DBIT(8), .OS_TICK(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .baud_en(baud_w[2]));

  uart_tx_ctrl #(.DBIT(8), .OS_TICK(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) dut_sb32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .baud_en(baud_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic acceptByte(input logic [7:0] data);
    @(negedge clk);
    tx_data  = data;
    tx_start = 1'b1;
    s_tick   = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    s_tick   = 1'b0;
  endtask

  task automatic giveTicks(input int count);
    for (int n = 0; n < count; n++) begin
      @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  endtask

  // Sample tx just before each tick so it shows the state after the previous tick.
  task automatic captureFrame(input int nticks, input int inject_at);
    for (int i = 0; i < 4; i++) begin
      cap[i]      = '0;
      done_idx[i] = -1;
      done_cnt[i] = 0;
      busy_ok[i]  = 1'b1;
    end
    for (int n = 0; n < nticks; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (n % 16 == 8) cap[i][4'(n / 16)] = tx_w[i];
        if (done_cnt[i] == 0) busy_ok[i] = busy_ok[i] & busy_w[i] & baud_w[i];
      end
      s_tick = 1'b1;
      if (n == inject_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          done_cnt[i]++;
          done_idx[i] = n;
        end
      end
      @(negedge clk);
      s_tick = 1'b0;
      if (n == inject_at) tx_start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int v);
    logic [10:0] exp;
    logic        p9;
    acceptByte(vecs[v].data);
    captureFrame(176, vecs[v].inject_at);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      p9  = (i == 1) ? vecs[v].par_even : (i == 2) ? ~vecs[v].par_even : 1'b1;
      exp = {1'b1, p9, vecs[v].data, 1'b0};
      checkOutput($sformatf("v%0d dut%0d frame", v, i), 32'(cap[i]), 32'(exp));
      checkOutput($sformatf("v%0d dut%0d done_idx", v, i), 32'(done_idx[i]),
                  (i == 0) ? 32'd159 : 32'd175);
      checkOutput($sformatf("v%0d dut%0d done_cnt", v, i), 32'(done_cnt[i]), 32'd1);
      checkOutput($sformatf("v%0d dut%0d busy_held", v, i), 32'(busy_ok[i]), 32'd1);
      checkOutput($sformatf("v%0d dut%0d idle_after", v, i),
                  {28'd0, tx_w[i], busy_w[i], done_w[i], baud_w[i]}, 32'b1000);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    s_tick     = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;

    vecs[0] = '{data: 8'hA5, par_even: 1'b0, inject_at: -1};
    vecs[1] = '{data: 8'h07, par_even: 1'b1, inject_at: -1};
    vecs[2] = '{data: 8'h3C, par_even: 1'b0, inject_at: -1};
    vecs[3] = '{data: 8'h01, par_even: 1'b1, inject_at: -1};
    vecs[4] = '{data: 8'hFE, par_even: 1'b1, inject_at: -1};
    vecs[5] = '{data: 8'h96, par_even: 1'b0, inject_at: 50};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("reset dut%0d", i),
                  {28'd0, tx_w[i], busy_w[i], done_w[i], baud_w[i]}, 32'b1000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) applyStimulus(v);

    // Back-to-back with tx_start held high: 0x55 then 0x3C on the plain instance.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    captureFrame(160, -1);
    checkOutput("b2b first frame", 32'(cap[0][9:0]), 32'({1'b1, 8'h55, 1'b0}));
    checkOutput("b2b first done_idx", 32'(done_idx[0]), 32'd159);
    checkOutput("b2b gap clk", {30'd0, tx_w[0], busy_w[0]}, 32'b10);
    @(negedge clk);
    checkOutput("b2b accepted next clk", {30'd0, tx_w[0], busy_w[0]}, 32'b11);
    tx_start = 1'b0;
    captureFrame(176, -1);
    checkOutput("b2b second frame", 32'(cap[0]), 32'({2'b11, 8'h3C, 1'b0}));
    checkOutput("b2b second done_idx", 32'(done_idx[0]), 32'd159);
    checkOutput("b2b second done_cnt", 32'(done_cnt[0]), 32'd1);
    repeat (4) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xC3, then a fresh frame.
    acceptByte(8'hC3);
    giveTicks(72);
    @(negedge clk);
    checkOutput("pre-reset mid bit3", {30'd0, tx_w[0], busy_w[0]}, 32'b01);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("async reset dut%0d", i),
                  {28'd0, tx_w[i], busy_w[i], done_w[i], baud_w[i]}, 32'b1000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    acceptByte(8'h5A);
    captureFrame(176, -1);
    checkOutput("post-reset plain frame", 32'(cap[0]), 32'({2'b11, 8'h5A, 1'b0}));
    checkOutput("post-reset even frame", 32'(cap[1]), 32'({2'b10, 8'h5A, 1'b0}));
    checkOutput("post-reset odd frame", 32'(cap[2]), 32'({2'b11, 8'h5A, 1'b0}));
    checkOutput("post-reset sb32 done_idx", 32'(done_idx[3]), 32'd175);
    checkOutput("post-reset plain done_idx", 32'(done_idx[0]), 32'd159);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
